// File: rtl/reflet_irq_arbiter.sv
// reflet_irq_arbiter: 8-source interrupt controller. Rising edges on irq_in
// are latched in PENDING; one masked-in pending source at a time is presented
// to the CPU over an int_req/int_ack handshake and held in service until an
// end-of-interrupt (EOI) write.
//
// Register window (4 bytes at base_addr, reads zero-extended to wordsize):
//   0 PENDING  R: pending[7:0]   W1C
//   1 MASK     RW: 1 = source enabled
//   2 STATUS   R: {busy, 4'b0, int_num}; any write = EOI
//   3 CTRL     RW: bit0 global enable; bit1 reads 1 when round-robin is built
//
// Ports:
//   clk, reset (async, active-low)
//   enable, addr, write_en, data_in, data_out : system bus slave
//   irq_in   : peripheral interrupt lines (level, active-high)
//   int_req  : interrupt request to CPU
//   int_num  : index of the requested / in-service source
//   int_ack  : CPU acknowledge
//
// Optional feature: define REFLET_IRQ_ROUND_ROBIN_EN to replace fixed
// lowest-index priority with round-robin starting after the last grant.
module reflet_irq_arbiter #(
  parameter int unsigned                 wordsize       = 16,
  parameter int unsigned                 base_addr_size = 16,
  parameter logic [base_addr_size-1:0]   base_addr      = 16'hFF10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [base_addr_size-1:0] addr,
  input  logic                      write_en,
  input  logic [wordsize-1:0]       data_in,
  output logic [wordsize-1:0]       data_out,
  input  logic [7:0]                irq_in,
  output logic                      int_req,
  output logic [2:0]                int_num,
  input  logic                      int_ack
);

  // One extra bit so base_addr+4 cannot wrap at the top of the address map
  localparam int unsigned addr_ext_w = base_addr_size + 1;

`ifdef REFLET_IRQ_ROUND_ROBIN_EN
  localparam logic rr_present = 1'b1;
`else
  localparam logic rr_present = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] pending_q, pending_d;
  logic [7:0] mask_q, mask_d;
  logic       ctrl_q, ctrl_d;
  logic [7:0] prev_irq_q;
  logic [2:0] int_num_q, int_num_d;
  logic       int_req_q, int_req_d;

  logic                      sel_c;
  logic [base_addr_size-1:0] addr_off;
  logic [1:0]                offset;
  logic                      wr_c;
  logic                      eoi_c;
  logic [7:0]                w1c_c;
  logic [7:0]                ack_clr_c;
  logic [7:0]                req_vec_c;
  logic [2:0]                winner_c;
  logic [7:0]                rd_byte;

  // Bus decode
  assign sel_c    = enable && (addr >= base_addr) &&
                    (addr_ext_w'(addr) < (addr_ext_w'(base_addr) + addr_ext_w'(4)));
  assign addr_off = addr - base_addr;
  assign offset   = addr_off[1:0];
  assign wr_c     = sel_c && write_en;
  assign eoi_c    = wr_c && (offset == 2'd2);
  assign w1c_c    = (wr_c && (offset == 2'd0)) ? data_in[7:0] : 8'h00;

  // Only the low byte of the write bus and the window offset carry meaning
  logic unused_bits;
  assign unused_bits = ^{data_in, addr_off};

  // Combinational register read
  always_comb begin
    rd_byte = 8'h00;
    if (sel_c) begin
      case (offset)
        2'd0:    rd_byte = pending_q;
        2'd1:    rd_byte = mask_q;
        2'd2:    rd_byte = {(state_q != IDLE), 4'b0000, int_num_q};
        default: rd_byte = {6'b000000, rr_present, ctrl_q};
      endcase
    end
  end
  assign data_out = wordsize'(rd_byte);

  assign req_vec_c = pending_q & mask_q;

`ifdef REFLET_IRQ_ROUND_ROBIN_EN
  logic [2:0] last_grant_q, last_grant_d;

  // Search upward from last_grant+1; k=8 wraps back to last_grant itself
  always_comb begin
    winner_c = 3'd0;
    for (int k = 8; k >= 1; k--) begin
      if (req_vec_c[last_grant_q + 3'(k)]) winner_c = last_grant_q + 3'(k);
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if ((state_q == REQ) && int_ack) last_grant_d = int_num_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_grant_q <= 3'd0;
    else        last_grant_q <= last_grant_d;
  end
`else
  // Fixed priority: lowest index wins
  always_comb begin
    winner_c = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req_vec_c[i]) winner_c = 3'(i);
    end
  end
`endif

  // Next-state, handshake and register updates
  always_comb begin
    state_d   = state_q;
    int_num_d = int_num_q;
    ack_clr_c = 8'h00;
    mask_d    = mask_q;
    ctrl_d    = ctrl_q;

    case (state_q)
      IDLE: begin
        if (ctrl_q && (|req_vec_c)) begin
          state_d   = REQ;
          int_num_d = winner_c;
        end
      end
      REQ: begin
        if (int_ack) begin
          state_d   = SERVICE;
          ack_clr_c = 8'h01 << int_num_q;
        end
      end
      SERVICE: begin
        if (eoi_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    int_req_d = (state_d == REQ);

    if (wr_c && (offset == 2'd1)) mask_d = data_in[7:0];
    if (wr_c && (offset == 2'd3)) ctrl_d = data_in[0];

    // A new edge wins over a W1C or ack clear on the same cycle
    pending_d = (pending_q & ~(w1c_c | ack_clr_c)) | (irq_in & ~prev_irq_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      pending_q  <= 8'h00;
      mask_q     <= 8'h00;
      ctrl_q     <= 1'b0;
      prev_irq_q <= 8'h00;
      int_num_q  <= 3'd0;
      int_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      ctrl_q     <= ctrl_d;
      prev_irq_q <= irq_in;
      int_num_q  <= int_num_d;
      int_req_q  <= int_req_d;
    end
  end

  assign int_req = int_req_q;
  assign int_num = int_num_q;

endmodule

// File: tb/tb_reflet_irq_arbiter.sv
// Self-checking bench for reflet_irq_arbiter. Expected grant indices are
// pushed to a queue when interrupts are pulsed and popped when int_req rises.
module tb_reflet_irq_arbiter;

  localparam logic [15:0] BASE = 16'hFF10;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [15:0] addr;
  logic        write_en;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic [7:0]  irq_in;
  logic        int_req;
  logic [2:0]  int_num;
  logic        int_ack;

  int         checks;
  int         errors;
  int         exp_q[$];
  logic [2:0] tb_last;
  logic [15:0] rd;

`ifdef REFLET_IRQ_ROUND_ROBIN_EN
  localparam logic [15:0] CTRL_FLAG = 16'h0002;
`else
  localparam logic [15:0] CTRL_FLAG = 16'h0000;
`endif

  reflet_irq_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .addr     (addr),
    .write_en (write_en),
    .data_in  (data_in),
    .data_out (data_out),
    .irq_in   (irq_in),
    .int_req  (int_req),
    .int_num  (int_num),
    .int_ack  (int_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] off, input logic [7:0] d);
    enable   = 1'b1;
    addr     = BASE + 16'(off);
    write_en = 1'b1;
    data_in  = {8'h00, d};
    tick();
    enable   = 1'b0;
    write_en = 1'b0;
    data_in  = 16'h0000;
    addr     = 16'h0000;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
    enable   = 1'b1;
    addr     = a;
    write_en = 1'b0;
    #1;
    d        = data_out;
    enable   = 1'b0;
    addr     = 16'h0000;
  endtask

  task automatic pulse(input logic [7:0] m);
    irq_in = irq_in | m;
    tick();
    irq_in = irq_in & ~m;
  endtask

  task automatic do_ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  task automatic do_eoi();
    bus_write(2'd2, 8'h00);
  endtask

  // Reference choice of the next grant for a pending&mask set
  function automatic logic [2:0] pick(input logic [7:0] p, input logic [2:0] last);
    logic [2:0] r;
    bit         found;
    r     = 3'd0;
    found = 0;
`ifdef REFLET_IRQ_ROUND_ROBIN_EN
    for (int k = 1; k <= 8; k++) begin
      int idx;
      idx = (int'(last) + k) % 8;
      if (!found && p[idx]) begin
        r     = 3'(idx);
        found = 1;
      end
    end
`else
    for (int i = 0; i < 8; i++) begin
      if (!found && p[i]) begin
        r     = 3'(i);
        found = 1;
      end
    end
    if (last == 3'd7) r = r;
`endif
    return r;
  endfunction

  // Push the full service order for a set that will be drained in sequence
  task automatic push_order(input logic [7:0] p);
    logic [7:0] rem;
    logic [2:0] w;
    rem = p;
    while (rem != 8'h00) begin
      w = pick(rem, tb_last);
      exp_q.push_back(int'(w));
      tb_last = w;
      rem[w]  = 1'b0;
    end
  endtask

  // Bounded wait for int_req, then score int_num against the queue head
  task automatic wait_req(input string name);
    int n;
    int e;
    n = 0;
    while (!int_req && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (!int_req || exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s int_req got %b want 1 (queue depth %0d)", name, int_req, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if (int'(int_num) !== e) begin
        errors++;
        $display("FAIL %s int_num got %0d want %0d", name, int_num, e);
      end
    end
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    irq_in   = 8'hFF;
    enable   = 1'b0;
    addr     = 16'h0000;
    write_en = 1'b0;
    data_in  = 16'h0000;
    int_ack  = 1'b0;
    tb_last  = 3'd0;
    repeat (3) tick();
    checks++;
    if (int_req !== 1'b0 || int_num !== 3'd0) begin
      errors++;
      $display("FAIL reset_outputs got req=%b num=%0d want req=0 num=0", int_req, int_num);
    end
    for (int i = 0; i < 4; i++) begin
      logic [15:0] want;
      want = (i == 3) ? CTRL_FLAG : 16'h0000;
      bus_read(BASE + 16'(i), rd);
      checks++;
      if (rd !== want) begin
        errors++;
        $display("FAIL reset_reg%0d got %h want %h", i, rd, want);
      end
    end
    irq_in = 8'h00;
    tick();
    reset = 1'b1;
    tick();
    bus_read(BASE, rd);
    checks++;
    if (rd !== 16'h0000) begin
      errors++;
      $display("FAIL reset_pending_after_release got %h want 0000", rd);
    end
  endtask

  task automatic test_decode();
    bus_write(2'd1, 8'hA5);
    bus_read(BASE + 16'd4, rd);
    checks++;
    if (rd !== 16'h0000) begin
      errors++;
      $display("FAIL read_outside_window got %h want 0000", rd);
    end
    enable = 1'b0;
    addr   = BASE + 16'd1;
    #1;
    checks++;
    if (data_out !== 16'h0000) begin
      errors++;
      $display("FAIL read_disabled got %h want 0000", data_out);
    end
    addr = 16'h0000;
    bus_read(BASE + 16'd1, rd);
    checks++;
    if (rd !== 16'h00A5) begin
      errors++;
      $display("FAIL mask_readback got %h want 00a5", rd);
    end
  endtask

  task automatic test_basic();
    bus_write(2'd1, 8'h04);
    bus_write(2'd3, 8'h01);
    bus_read(BASE + 16'd3, rd);
    checks++;
    if (rd !== (CTRL_FLAG | 16'h0001)) begin
      errors++;
      $display("FAIL ctrl_readback got %h want %h", rd, CTRL_FLAG | 16'h0001);
    end
    push_order(8'h04);
    pulse(8'h04);
    bus_read(BASE, rd);
    checks++;
    if (rd !== 16'h0004 || int_req !== 1'b0) begin
      errors++;
      $display("FAIL basic_edge_k got pend=%h req=%b want pend=0004 req=0", rd, int_req);
    end
    tick();
    checks++;
    if (int_req !== 1'b1) begin
      errors++;
      $display("FAIL basic_req_latency got %b want 1", int_req);
    end
    wait_req("basic_grant");
    do_ack();
    bus_read(BASE, rd);
    checks++;
    if (int_req !== 1'b0 || rd !== 16'h0000) begin
      errors++;
      $display("FAIL basic_ack got req=%b pend=%h want req=0 pend=0000", int_req, rd);
    end
    bus_read(BASE + 16'd2, rd);
    checks++;
    if (rd !== 16'h0082) begin
      errors++;
      $display("FAIL basic_status_service got %h want 0082", rd);
    end
    do_eoi();
    bus_read(BASE + 16'd2, rd);
    checks++;
    if (rd !== 16'h0002) begin
      errors++;
      $display("FAIL basic_status_idle got %h want 0002", rd);
    end
  endtask

  task automatic test_priority();
    bus_write(2'd1, 8'hFF);
    push_order(8'h22);
    pulse(8'h22);
    wait_req("prio_first");
    do_ack();
    do_eoi();
    wait_req("prio_second");
    do_ack();
    do_eoi();
    bus_read(BASE, rd);
    checks++;
    if (rd !== 16'h0000) begin
      errors++;
      $display("FAIL prio_drained got %h want 0000", rd);
    end
  endtask

  task automatic test_masked();
    bus_write(2'd1, 8'h00);
    pulse(8'h08);
    repeat (2) tick();
    bus_read(BASE, rd);
    checks++;
    if (rd !== 16'h0008 || int_req !== 1'b0) begin
      errors++;
      $display("FAIL masked_hold got pend=%h req=%b want pend=0008 req=0", rd, int_req);
    end
    push_order(8'h08);
    bus_write(2'd1, 8'h08);
    wait_req("masked_unmask");
    do_ack();
    do_eoi();
    bus_write(2'd1, 8'h00);
    pulse(8'h08);
    bus_write(2'd0, 8'h08);
    bus_write(2'd1, 8'h08);
    repeat (2) tick();
    bus_read(BASE, rd);
    checks++;
    if (rd !== 16'h0000 || int_req !== 1'b0) begin
      errors++;
      $display("FAIL w1c_before_unmask got pend=%h req=%b want pend=0000 req=0", rd, int_req);
    end
  endtask

  task automatic test_service_repulse();
    bus_write(2'd1, 8'h01);
    push_order(8'h01);
    pulse(8'h01);
    wait_req("svc_first");
    do_ack();
    pulse(8'h01);
    repeat (3) tick();
    bus_read(BASE, rd);
    checks++;
    if (rd !== 16'h0001 || int_req !== 1'b0) begin
      errors++;
      $display("FAIL svc_repulse got pend=%h req=%b want pend=0001 req=0", rd, int_req);
    end
    push_order(8'h01);
    do_eoi();
    checks++;
    if (int_req !== 1'b0) begin
      errors++;
      $display("FAIL eoi_latency got req=%b want 0", int_req);
    end
    wait_req("svc_rerequest");
    // Ack and a fresh source-0 edge on the same clock: the edge must survive
    int_ack = 1'b1;
    irq_in  = 8'h01;
    tick();
    int_ack = 1'b0;
    irq_in  = 8'h00;
    bus_read(BASE, rd);
    checks++;
    if (rd !== 16'h0001 || int_req !== 1'b0) begin
      errors++;
      $display("FAIL ack_set_collision got pend=%h req=%b want pend=0001 req=0", rd, int_req);
    end
    push_order(8'h01);
    do_eoi();
    wait_req("collision_rerequest");
    do_ack();
    do_eoi();
  endtask

  task automatic test_back_to_back();
    logic [2:0] w;
    bus_write(2'd1, 8'h03);
    pulse(8'h03);
    for (int i = 0; i < 4; i++) begin
      w = pick(8'h03, tb_last);
      exp_q.push_back(int'(w));
      tb_last = w;
      wait_req("b2b_grant");
      do_ack();
      if (i < 3) pulse(8'h03);
      else begin
        bus_write(2'd3, 8'h00);
        bus_write(2'd0, 8'hFF);
      end
      do_eoi();
    end
    repeat (2) tick();
    bus_read(BASE + 16'd2, rd);
    checks++;
    if (rd[7] !== 1'b0 || int_req !== 1'b0) begin
      errors++;
      $display("FAIL b2b_cleanup got status=%h req=%b want busy=0 req=0", rd, int_req);
    end
  endtask

  task automatic test_reset_mid();
    bus_write(2'd3, 8'h01);
    bus_write(2'd1, 8'h10);
    push_order(8'h10);
    pulse(8'h10);
    wait_req("midreset_req");
    #2;
    reset = 1'b0;
    #1;
    bus_read(BASE + 16'd2, rd);
    checks++;
    if (int_req !== 1'b0 || int_num !== 3'd0 || rd !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid_req got req=%b num=%0d status=%h want 0 0 0000", int_req, int_num, rd);
    end
    tick();
    reset   = 1'b1;
    tb_last = 3'd0;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_decode();
    test_basic();
    test_priority();
    test_masked();
    test_service_repulse();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
